// File: rtl/knn_vote.sv
// knn_vote -- majority-vote classifier stage of the KNN pipeline.
//
// Captures the K nearest entries of the ascending-sorted distance/type arrays
// on a valid_sort pulse, tallies one label per cycle (COUNT), then scans every
// class for the winner one class per cycle (SELECT) and strobes the result.
// Latency from the capture edge to class_valid is K + 2^TYPE_W cycles.
//
// Ports:
//   clk                    in   rising-edge clock
//   rst                    in   synchronous, active-high reset
//   valid_sort             in   one-cycle pulse, sorted arrays valid
//   distance_array_sorted  in   W*L, entry i at [W*i +: W], entry 0 nearest
//   type_array_sorted      in   TYPE_W*L, entry i label at [TYPE_W*i +: TYPE_W]
//   class_out              out  winning class (held until next result)
//   votes_out              out  vote count of the winning class
//   class_valid            out  one-cycle result strobe
//   busy                   out  high while an operation is in flight
//   overrun                out  sticky, set when a valid_sort is dropped
//
// Build option: define KNN_VOTE_TIE_NEAREST_EN to break vote ties in favour of
// the class whose nearest member has the lowest rank; otherwise the lowest
// class index wins a tie.
//
// state  | meaning
// IDLE   | waiting for valid_sort; capture and clear tallies on the pulse
// COUNT  | tally label of entry idx, idx = 0..K-1
// SELECT | compare class sel_c against the running best, sel_c = 0..NC-1

module knn_vote #(
  parameter int L      = 64,
  parameter int W      = 16,
  parameter int TYPE_W = 3,
  parameter int K      = 5,
  localparam int NC    = 1 << TYPE_W,
  localparam int CW    = $clog2(K + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_sort,
  input  logic [W*L-1:0]        distance_array_sorted,
  input  logic [TYPE_W*L-1:0]   type_array_sorted,
  output logic [TYPE_W-1:0]     class_out,
  output logic [CW-1:0]         votes_out,
  output logic                  class_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, SELECT} state_t;

  state_t            state;
  logic [TYPE_W-1:0] type_q     [K];
  logic [W-1:0]      dist_q     [K];
  logic [CW-1:0]     votes      [NC];
  logic [CW-1:0]     first_rank [NC];
  logic [IW-1:0]     idx;
  logic [TYPE_W-1:0] sel_c;
  logic [TYPE_W-1:0] best_class;
  logic [CW-1:0]     best_votes;
  logic [CW-1:0]     best_rank;

  logic [TYPE_W-1:0] cur_t;
  logic              take;
  logic              unused_dbg;

  always_comb begin
    cur_t = type_q[idx];
    take  = 1'b0;
    // Class 0 seeds the running best on the first SELECT cycle.
    if (sel_c == '0) begin
      take = 1'b1;
    end else if (votes[sel_c] > best_votes) begin
      take = 1'b1;
    end else if (votes[sel_c] == best_votes) begin
`ifdef KNN_VOTE_TIE_NEAREST_EN
      take = (first_rank[sel_c] < best_rank);
`else
      take = 1'b0;
`endif
    end
  end

  // Distances are held for debug visibility only; fold them (and the input
  // entries beyond K, which are never read) into a dead reduction.
  always_comb begin
    unused_dbg = ^distance_array_sorted ^ ^type_array_sorted ^ ^best_rank;
    for (int i = 0; i < K; i++) begin
      unused_dbg = unused_dbg ^ ^dist_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      sel_c       <= '0;
      best_class  <= '0;
      best_votes  <= '0;
      best_rank   <= '0;
      class_out   <= '0;
      votes_out   <= '0;
      class_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      for (int c = 0; c < NC; c++) begin
        votes[c]      <= '0;
        first_rank[c] <= '0;
      end
      for (int i = 0; i < K; i++) begin
        type_q[i] <= '0;
        dist_q[i] <= '0;
      end
    end else begin
      class_valid <= 1'b0;
      if (valid_sort && busy) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (valid_sort) begin
            for (int i = 0; i < K; i++) begin
              type_q[i] <= type_array_sorted[TYPE_W*i +: TYPE_W];
              dist_q[i] <= distance_array_sorted[W*i +: W];
            end
            // first_rank == K marks a class with no members among the K.
            for (int c = 0; c < NC; c++) begin
              votes[c]      <= '0;
              first_rank[c] <= CW'(K);
            end
            idx   <= '0;
            busy  <= 1'b1;
            state <= COUNT;
          end
        end
        COUNT: begin
          votes[cur_t] <= votes[cur_t] + CW'(1);
          if (first_rank[cur_t] == CW'(K)) begin
            first_rank[cur_t] <= CW'(idx);
          end
          if (idx == IW'(K - 1)) begin
            idx   <= '0;
            sel_c <= '0;
            state <= SELECT;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        SELECT: begin
          if (take) begin
            best_class <= sel_c;
            best_votes <= votes[sel_c];
            best_rank  <= first_rank[sel_c];
          end
          if (sel_c == TYPE_W'(NC - 1)) begin
            class_out   <= take ? sel_c : best_class;
            votes_out   <= take ? votes[sel_c] : best_votes;
            class_valid <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            sel_c <= sel_c + TYPE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
module tb_knn_vote;
  localparam int L      = 64;
  localparam int W      = 16;
  localparam int TYPE_W = 3;
  localparam int K      = 5;
  localparam int NC     = 1 << TYPE_W;
  localparam int CW     = $clog2(K + 1);
  localparam int LAT    = K + NC;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                valid_sort = 1'b0;
  logic [W*L-1:0]      dist_arr = '0;
  logic [TYPE_W*L-1:0] type_arr = '0;
  logic [TYPE_W-1:0]   class_out;
  logic [CW-1:0]       votes_out;
  logic                class_valid;
  logic                busy;
  logic                overrun;

  int total = 0;
  int bad   = 0;

  knn_vote #(.L(L), .W(W), .TYPE_W(TYPE_W), .K(K)) dut (
    .clk(clk),
    .rst(rst),
    .valid_sort(valid_sort),
    .distance_array_sorted(dist_arr),
    .type_array_sorted(type_arr),
    .class_out(class_out),
    .votes_out(votes_out),
    .class_valid(class_valid),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference classifier: count labels of the K nearest entries, find the top
  // count, then resolve ties by nearest member or by lowest class index.
  task automatic model_classify(input logic [TYPE_W*L-1:0] ta,
                                output int cls, output int vts);
    int cnt[NC];
    int first[NC];
    int maxv;
    for (int c = 0; c < NC; c++) begin
      cnt[c]   = 0;
      first[c] = L + 1;
    end
    for (int i = 0; i < K; i++) begin
      int t;
      t = int'(ta[TYPE_W*i +: TYPE_W]);
      cnt[t]++;
      if (i < first[t]) first[t] = i;
    end
    maxv = 0;
    for (int c = 0; c < NC; c++) if (cnt[c] > maxv) maxv = cnt[c];
    cls = -1;
    for (int c = 0; c < NC; c++) begin
      if (cnt[c] == maxv) begin
`ifdef KNN_VOTE_TIE_NEAREST_EN
        if (cls < 0 || first[c] < first[cls]) cls = c;
`else
        if (cls < 0) cls = c;
`endif
      end
    end
    vts = maxv;
  endtask

  // Cycle-level expectation: an accepted pulse makes the block busy for LAT
  // edges, then one strobe; pulses while busy only set the sticky flag.
  int m_rem = 0, m_busy = 0, m_valid = 0, m_cls = 0, m_vot = 0, m_ovr = 0;
  int m_pc = 0, m_pv = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_busy = 0; m_valid = 0; m_cls = 0; m_vot = 0; m_ovr = 0;
    end else begin
      m_valid = 0;
      if (m_busy != 0) begin
        if (valid_sort) m_ovr = 1;
        m_rem--;
        if (m_rem == 0) begin
          m_busy  = 0;
          m_valid = 1;
          m_cls   = m_pc;
          m_vot   = m_pv;
        end
      end else if (valid_sort) begin
        model_classify(type_arr, m_pc, m_pv);
        m_rem  = LAT;
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("class_valid", int'(class_valid), m_valid);
    check("busy", int'(busy), m_busy);
    check("overrun", int'(overrun), m_ovr);
    check("class_out", int'(class_out), m_cls);
    check("votes_out", int'(votes_out), m_vot);
  end

  task automatic load(input int t0, input int t1, input int t2, input int t3,
                      input int t4, input int tail);
    int lab[K];
    lab = '{t0, t1, t2, t3, t4};
    for (int i = 0; i < L; i++) begin
      type_arr[TYPE_W*i +: TYPE_W] = (i < K) ? TYPE_W'(lab[i]) : TYPE_W'(tail);
      dist_arr[W*i +: W]           = W'(i * 10 + 3);
    end
  endtask

  // Called at a negedge; the following posedge is the capture edge.
  task automatic pulse();
    valid_sort = 1'b1;
    @(negedge clk);
    valid_sort = 1'b0;
  endtask

  // Called at the negedge right after the capture edge.
  task automatic wait_result(input string name, input int exp_c,
                             input int exp_v, input int exp_lat);
    int n;
    n = 0;
    while (class_valid !== 1'b1 && n < 3 * LAT) begin
      @(negedge clk);
      n++;
    end
    if (class_valid !== 1'b1) begin
      check({name, "_timeout"}, n, exp_lat);
    end else begin
      if (exp_lat >= 0) check({name, "_latency"}, n, exp_lat);
      check({name, "_class"}, int'(class_out), exp_c);
      check({name, "_votes"}, int'(votes_out), exp_v);
      check({name, "_model_class"}, m_cls, exp_c);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int tie_exp, desc_exp, pair_exp;

  initial begin
`ifdef KNN_VOTE_TIE_NEAREST_EN
    tie_exp = 3; desc_exp = 7; pair_exp = 6;
`else
    tie_exp = 2; desc_exp = 3; pair_exp = 2;
`endif
    idle_cycles(2);
    check("reset_class", int'(class_out), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    idle_cycles(2);

    // basic majority
    load(1, 4, 1, 1, 6, 7);
    pulse();
    wait_result("basic", 1, 3, LAT);
    idle_cycles(3);

    // tie between 3 and 2
    load(3, 2, 3, 2, 1, 0);
    pulse();
    wait_result("tie", tie_exp, 2, LAT);
    idle_cycles(2);

    // all singletons
    load(7, 6, 5, 4, 3, 1);
    pulse();
    wait_result("desc", desc_exp, 1, LAT);
    idle_cycles(2);

    // pair tie, higher class nearer
    load(6, 6, 2, 2, 3, 0);
    pulse();
    wait_result("pair", pair_exp, 2, LAT);
    idle_cycles(2);

    // unanimous, tail ignored
    load(0, 0, 0, 0, 0, 5);
    pulse();
    wait_result("unanimous", 0, 5, LAT);

    // back-to-back: new pulse in the strobe cycle
    load(5, 2, 5, 5, 2, 4);
    pulse();
    check("b2b_overrun", int'(overrun), 0);
    wait_result("b2b", 5, 3, LAT);
    idle_cycles(4);

    // overrun: second pulse 4 cycles after capture is dropped
    load(1, 4, 1, 1, 6, 7);
    pulse();
    idle_cycles(3);
    load(2, 2, 2, 2, 2, 2);
    pulse();
    wait_result("ovr_first", 1, 3, LAT - 4);
    idle_cycles(LAT + 5);
    check("ovr_sticky", int'(overrun), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ovr_cleared", int'(overrun), 0);

    // reset mid-op, 3 cycles after capture
    load(4, 4, 1, 4, 0, 6);
    pulse();
    idle_cycles(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    idle_cycles(LAT + 3);
    load(4, 4, 1, 4, 0, 6);
    pulse();
    wait_result("after_rst", 4, 3, LAT);

    // reset and pulse together: nothing captured
    load(3, 3, 3, 3, 3, 3);
    rst = 1'b1;
    valid_sort = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    valid_sort = 1'b0;
    check("rst_wins_busy", int'(busy), 0);
    idle_cycles(LAT + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
